uart_rx_core: RTL and testbench

UART receive core for the DE-board UART design: recovers 8N1 (optionally 8E1) frames from the asynchronous `GPIO_0` RX pin using 16x oversampling and presents each byte on a held-until-acknowledged output register. It sits directly downstream of the RX pin and upstream of the HEX display / flag logic. It shares the board's baud-select switches with the TX path and its enable semantics.

---
 rtl/uart_rx_core_if.sv | 38 +++
 rtl/uart_rx_core.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: byte-delivery handshake between the UART receive core and
// its consumer (HEX display / flag logic).
//
//   rx_data    [7:0]  received byte, held until acknowledged
//   rx_valid          rx_data holds an unacknowledged byte
//   rx_ack            consumer acknowledge, one-cycle pulse
//   frame_err         sticky: a stop bit was sampled low
//   overrun           sticky: a frame completed while rx_valid was still 1
//   parity_err        sticky: even-parity mismatch (0 when parity is not built)
//
// master: the receive core (drives data and flags, samples rx_ack)
// slave : the consumer
interface uart_rx_core_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output parity_err,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  parity_err,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampling UART receiver for 8N1 frames (8E1 when
// UART_RX_PARITY_EN is defined). The RX pin is double-synchronized, each bit
// is decided by a majority vote of samples 7, 8 and 9, and every byte is held
// on rx_if until the consumer acknowledges it.
//
// Ports:
//   clk        system clock (50 MHz)
//   rst        synchronous, active-high reset
//   en         UART enable; 0 behaves exactly like rst
//   rx_en      receiver enable; 0 blocks new start bits only
//   baud_sel   00=4800, 01=9600, 10=19200, 11=115200 (latched while idle)
//   rx         asynchronous serial input, idle high
//   rx_if      master side of uart_rx_core_if (byte, valid, ack, sticky flags)
//
// Build option: UART_RX_PARITY_EN adds an even-parity bit after the data and
// makes parity_err live; without it parity_err is held at 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line idle, waiting for a 1->0 edge with rx_en=1
// S_START  | inside the start bit; a vote of 1 means a false start
// S_DATA   | shifting the data bits in, LSB first
// S_PARITY | checking the even-parity bit (parity build only)
// S_STOP   | voting the stop bit and delivering the byte
module uart_rx_core #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int DATA_BITS = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           rx_en,
    input  logic [1:0]     baud_sel,
    input  logic           rx,
    uart_rx_core_if.master rx_if
);
    // Divisor per 16x tick, rounded to nearest: 651 / 326 / 163 / 27 at 50 MHz.
    localparam logic [9:0] DIV_4800_M1   = 10'((CLK_HZ + 8 * 4800)   / (16 * 4800)   - 1);
    localparam logic [9:0] DIV_9600_M1   = 10'((CLK_HZ + 8 * 9600)   / (16 * 9600)   - 1);
    localparam logic [9:0] DIV_19200_M1  = 10'((CLK_HZ + 8 * 19200)  / (16 * 19200)  - 1);
    localparam logic [9:0] DIV_115200_M1 = 10'((CLK_HZ + 8 * 115200) / (16 * 115200) - 1);
    localparam logic [2:0] LAST_BIT      = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic                 soft_clr;
    logic                 sync1_q, sync1_d;
    logic                 rx_s_q, rx_s_d;
    logic                 rx_prev_q, rx_prev_d;
    logic [1:0]           sel_q, sel_d;
    logic [9:0]           div_cnt_q, div_cnt_d;
    logic [9:0]           div_m1;
    logic                 tick16;
    logic                 start_det;
    logic [3:0]           samp_q, samp_d, samp_nxt;
    logic                 vote_now, bit_end, maj;
    logic [2:0]           bit_q, bit_d;
    logic                 s7_q, s7_d, s8_q, s8_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    state_t               state_q, state_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err_q, parity_err_d;
`endif

    assign soft_clr = rst | ~en;

    // Synchronizer, edge detect, baud select latch and tick divider.
    always_comb begin
        sync1_d   = rx;
        rx_s_d    = sync1_q;
        rx_prev_d = rx_s_q;
        sel_d     = (state_q == S_IDLE) ? baud_sel : sel_q;

        case (sel_q)
            2'b00:   div_m1 = DIV_4800_M1;
            2'b01:   div_m1 = DIV_9600_M1;
            2'b10:   div_m1 = DIV_19200_M1;
            default: div_m1 = DIV_115200_M1;
        endcase

        tick16    = (div_cnt_q == div_m1);
        start_det = (state_q == S_IDLE) && rx_en && rx_prev_q && !rx_s_q;

        // Restart on a start edge so sample 8 lands mid-bit, and on a rate
        // change so the count can never sit above the new terminal value.
        if (start_det || (sel_d != sel_q) || tick16) begin
            div_cnt_d = 10'd0;
        end else begin
            div_cnt_d = div_cnt_q + 10'd1;
        end

        samp_nxt = samp_q + 4'd1;
        vote_now = tick16 && (samp_nxt == 4'd9);
        bit_end  = tick16 && (samp_nxt == 4'd0);
        maj      = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
    end

    // Frame FSM and delivery.
    always_comb begin
        state_d      = state_q;
        samp_d       = samp_q;
        bit_d        = bit_q;
        s7_d         = s7_q;
        s8_d         = s8_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif

        if (rx_if.rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
        end

        if ((state_q != S_IDLE) && tick16) begin
            samp_d = samp_nxt;
            if (samp_nxt == 4'd7) s7_d = rx_s_q;
            if (samp_nxt == 4'd8) s8_d = rx_s_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start_det) begin
                    state_d = S_START;
                    samp_d  = 4'd0;
                    bit_d   = 3'd0;
                end
            end
            S_START: begin
                if (vote_now && maj) begin
                    state_d = S_IDLE;
                end else if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (vote_now) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                end
                if (bit_end) begin
                    if (bit_q == LAST_BIT) begin
                        bit_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (vote_now && (maj != ^shift_q)) begin
                    parity_err_d = 1'b1;
                end
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (vote_now) begin
                    if (!maj) begin
                        frame_err_d = 1'b1;
                    end
                    // A coincident ack frees the holding register this cycle.
                    if (!rx_valid_q || rx_if.rx_ack) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (soft_clr) begin
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            sel_q        <= 2'b00;
            div_cnt_q    <= 10'd0;
            samp_q       <= 4'd0;
            bit_q        <= 3'd0;
            s7_q         <= 1'b1;
            s8_q         <= 1'b1;
            shift_q      <= '0;
            state_q      <= S_IDLE;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q      <= sync1_d;
            rx_s_q       <= rx_s_d;
            rx_prev_q    <= rx_prev_d;
            sel_q        <= sel_d;
            div_cnt_q    <= div_cnt_d;
            samp_q       <= samp_d;
            bit_q        <= bit_d;
            s7_q         <= s7_d;
            s8_q         <= s8_d;
            shift_q      <= shift_d;
            state_q      <= state_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err = parity_err_q;
`else
    assign rx_if.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rx_en;
    logic [1:0] baud_sel;
    logic       rx;

    uart_rx_core_if rx_if ();

    uart_rx_core dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .rx_en    (rx_en),
        .baud_sel (baud_sel),
        .rx       (rx),
        .rx_if    (rx_if)
    );

    always #10 clk = ~clk;

    // Ticks from START entry to the stop-bit vote: whole bits before the stop
    // bit, times 16, plus 9 samples into the stop bit.
`ifdef UART_RX_PARITY_EN
    localparam int VOTE_TICKS = 10 * 16 + 9;
`else
    localparam int VOTE_TICKS = 9 * 16 + 9;
`endif
    localparam int D_FAST = 27;
    localparam int BIT_FAST = 16 * D_FAST;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] din;
        logic       stop_b;
        logic       ack_first;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_fe;
        logic       exp_ov;
    } vec_t;

    vec_t vecs [4];

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic v,
                           input logic fe, input logic ov, input logic pe);
        chk({tag, ".rx_data"},    {24'd0, rx_if.rx_data},    {24'd0, d});
        chk({tag, ".rx_valid"},   {31'd0, rx_if.rx_valid},   {31'd0, v});
        chk({tag, ".frame_err"},  {31'd0, rx_if.frame_err},  {31'd0, fe});
        chk({tag, ".overrun"},    {31'd0, rx_if.overrun},    {31'd0, ov});
        chk({tag, ".parity_err"}, {31'd0, rx_if.parity_err}, {31'd0, pe});
    endtask

    task automatic pulse_ack();
        rx_if.rx_ack = 1'b1;
        wait_cyc(1);
        rx_if.rx_ack = 1'b0;
    endtask

    // Drives one frame starting now (caller sits just after a rising edge with
    // the line idle), then leaves the line idle for a few cycles.
    task automatic send_frame(input logic [7:0] b, input logic par_b,
                              input logic stop_b, input int bc);
        rx = 1'b0;
        wait_cyc(bc);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(bc);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_b;
        wait_cyc(bc);
`endif
        rx = stop_b;
        wait_cyc(bc);
        rx = 1'b1;
        wait_cyc(8);
    endtask

    initial begin
        #(20 * 200_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         idle_bad;
        logic [7:0] m_data;
        logic       m_valid, m_fe, m_ov;
        logic [7:0] rb;
        logic       rstop, rack;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h11, 1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 1'b1};

        rst          = 1'b1;
        en           = 1'b1;
        rx_en        = 1'b1;
        rx           = 1'b1;
        baud_sel     = 2'b11;
        rx_if.rx_ack = 1'b0;
        wait_cyc(2);
        rst = 1'b0;

        // Reset and quiet idle line.
        chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            wait_cyc(1);
            if ({rx_if.rx_data, rx_if.rx_valid, rx_if.frame_err, rx_if.overrun,
                 rx_if.parity_err} != 12'd0)
                idle_bad++;
        end
        chk("idle_quiet", idle_bad, 0);

        // Quarter-bit glitch is a false start.
        rx = 1'b0;
        wait_cyc(BIT_FAST / 4);
        rx = 1'b1;
        wait_cyc(2 * BIT_FAST);
        chk_out("glitch", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // 19200 baud with exact delivery timing.
        baud_sel = 2'b10;
        wait_cyc(4);
        fork
            send_frame(8'h3C, 1'b0, 1'b1, 16 * 163);
            begin
                wait_cyc(2 + VOTE_TICKS * 163);
                chk("b19200.valid_before_vote", {31'd0, rx_if.rx_valid}, 32'd0);
                wait_cyc(1);
                chk("b19200.valid_after_vote", {31'd0, rx_if.rx_valid}, 32'd1);
                chk("b19200.data", {24'd0, rx_if.rx_data}, 32'h3C);
            end
        join
        chk("b19200.valid_held", {31'd0, rx_if.rx_valid}, 32'd1);
        pulse_ack();
        chk("b19200.ack_clears", {31'd0, rx_if.rx_valid}, 32'd0);

        // baud_sel changes mid-frame must not disturb the frame.
        baud_sel = 2'b11;
        wait_cyc(4);
        fork
            send_frame(8'h3C, 1'b0, 1'b1, BIT_FAST);
            begin
                wait_cyc(1000);
                baud_sel = 2'b00;
                wait_cyc(2000);
                baud_sel = 2'b11;
            end
        join
        chk_out("sel_change", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_ack();

        // Table of back-to-back frames at 115200.
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].ack_first) pulse_ack();
            send_frame(vecs[i].din, ^vecs[i].din, vecs[i].stop_b, BIT_FAST);
            chk_out($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_valid,
                    vecs[i].exp_fe, vecs[i].exp_ov, 1'b0);
        end

        // en=0 mid-frame aborts and clears, next frame is clean.
        fork
            send_frame(8'hC3, 1'b0, 1'b1, BIT_FAST);
            begin
                wait_cyc(2000);
                en = 1'b0;
                wait_cyc(3);
                chk_out("abort", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        join
        en = 1'b1;
        wait_cyc(4);
        send_frame(8'h96, 1'b0, 1'b1, BIT_FAST);
        chk_out("after_abort", 8'h96, 1'b1, 1'b0, 1'b0, 1'b0);

        // Ack coincident with the stop vote, then a true overrun.
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(4);
        send_frame(8'h11, 1'b0, 1'b1, BIT_FAST);
        chk_out("co_first", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        fork
            send_frame(8'h22, 1'b0, 1'b1, BIT_FAST);
            begin
                wait_cyc(2 + VOTE_TICKS * D_FAST);
                rx_if.rx_ack = 1'b1;
                wait_cyc(1);
                rx_if.rx_ack = 1'b0;
            end
        join
        chk_out("co_ack", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b1, BIT_FAST);
        chk_out("overrun", 8'h22, 1'b1, 1'b0, 1'b1, 1'b0);

        // Random frames against a frame-level reference model.
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(4);
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
            rack  = 1'($urandom_range(0, 1));
            if (rack) begin
                pulse_ack();
                m_valid = 1'b0;
            end
            send_frame(rb, ^rb, rstop, BIT_FAST);
            if (!rstop) m_fe = 1'b1;
            if (!m_valid) begin
                m_data  = rb;
                m_valid = 1'b1;
            end else begin
                m_ov = 1'b1;
            end
            chk_out($sformatf("rand%0d", i), m_data, m_valid, m_fe, m_ov, 1'b0);
        end

`ifdef UART_RX_PARITY_EN
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(4);
        send_frame(8'h07, 1'b1, 1'b1, BIT_FAST);
        chk_out("parity_good", 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_ack();
        send_frame(8'h07, 1'b0, 1'b1, BIT_FAST);
        chk_out("parity_bad", 8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
